// File: rtl/clk_gate_ctrl.sv
// Clock-enable controller for a gated global clock buffer.
// Requesters use a 4-phase req/ack handshake; the clock wakes, settles, serves, then idles off.
module clk_gate_ctrl #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned WAKE_CYCLES = 4,
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic [NUM_REQ-1:0] iReq,
    output logic [NUM_REQ-1:0] oAck,
    input  logic               iForceOn,
    output logic               oClkEn,
    output logic [1:0]         oState,
    output logic [15:0]        oWakeCnt
);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_WAKE = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               clk_en_q, clk_en_d;
    logic [15:0]        wake_cnt_q, wake_cnt_d;
    logic               any_req;

    assign any_req = (|iReq) | iForceOn;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        clk_en_d   = clk_en_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ST_OFF: begin
                clk_en_d = 1'b0;
                if (any_req) begin
                    state_d  = ST_WAKE;
                    clk_en_d = 1'b1;
                    cnt_d    = '0;
                    if (wake_cnt_q != 16'hFFFF) begin
                        wake_cnt_d = wake_cnt_q + 16'd1;
                    end
                end
            end
            ST_WAKE: begin
                // Settle always completes, even if every request has dropped meanwhile.
                if (cnt_q == WAKE_LAST) begin
                    state_d = ST_ON;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ON: begin
                ack_d = iReq;
                // Wait for all acks to fall before leaving so releasers see the handshake close.
                if (!any_req && (ack_q == '0)) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (any_req) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d  = ST_OFF;
                    clk_en_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_OFF;
                cnt_d    = '0;
                clk_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            ack_q      <= '0;
            clk_en_q   <= 1'b0;
            wake_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            clk_en_q   <= clk_en_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    assign oAck     = ack_q;
    assign oClkEn   = clk_en_q;
    assign oState   = state_q;
    assign oWakeCnt = wake_cnt_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed handshake scenarios plus randomized traffic,
// checked every cycle against a cycle-count model of the controller.
module tb_clk_gate_ctrl;

    localparam int NREQ = 4;
    localparam int WAKE = 4;
    localparam int IDLE = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic            force_on;
    logic            clk_en;
    logic [1:0]      state;
    logic [15:0]     wcnt;

    always #5 clk = ~clk;

    clk_gate_ctrl #(
        .NUM_REQ    (NREQ),
        .WAKE_CYCLES(WAKE),
        .IDLE_CYCLES(IDLE),
        .CNT_W      (8)
    ) dut (
        .iClock  (clk),
        .iReset  (rst),
        .iReq    (req),
        .oAck    (ack),
        .iForceOn(force_on),
        .oClkEn  (clk_en),
        .oState  (state),
        .oWakeCnt(wcnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: phase 0=off 1=waking 2=serving 3=idling; m_t counts edges spent in the phase.
    int              m_ph;
    int              m_t;
    logic [NREQ-1:0] m_ack;
    logic            m_en;
    int              m_wakes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_t = 0; m_ack = '0; m_en = 1'b0; m_wakes = 0;
    endtask

    task automatic model_edge();
        bit want;
        want = (req != '0) || force_on;
        case (m_ph)
            0: if (want) begin
                m_ph = 1; m_t = 0; m_en = 1'b1;
                if (m_wakes < 65535) m_wakes++;
            end
            1: begin
                m_t++;
                if (m_t == WAKE) m_ph = 2;
            end
            2: begin
                if (!want && m_ack == '0) begin
                    m_ph = 3; m_t = 0;
                end
                m_ack = req;
            end
            default: begin
                if (want) begin
                    m_ph = 2; m_t = 0;
                end else begin
                    m_t++;
                    if (m_t == IDLE) begin
                        m_ph = 0; m_en = 1'b0;
                    end
                end
            end
        endcase
        if (m_ph != 2) m_ack = '0;
    endtask

    task automatic compare_model();
        chk("clk_en", 32'(clk_en), 32'(m_en));
        chk("state", 32'(state), 32'(m_ph));
        chk("ack", 32'(ack), 32'(m_ack));
        chk("wake_cnt", 32'(wcnt), 32'(m_wakes));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    // Steps until the model reaches phase ph; an expired budget counts as a failure.
    task automatic run_until(input int ph, input int budget);
        int n;
        n = 0;
        while (m_ph != ph && n < budget) begin
            step();
            n++;
        end
        if (m_ph != ph) chk("run_until_timeout", 32'(m_ph), 32'(ph));
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_clk_en", 32'(clk_en), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_wake_cnt", 32'(wcnt), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [15:0] w_saved;
        bit          en_low;
        bit          ack2_seen;

        rst = 1'b1; req = '0; force_on = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_clk_en", 32'(clk_en), 32'd0);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_wake_cnt", 32'(wcnt), 32'd0);

        // Idle for 100 cycles.
        repeat (100) step();
        chk("idle_clk_en", 32'(clk_en), 32'd0);
        chk("idle_wake_cnt", 32'(wcnt), 32'd0);

        // Single request from OFF, release before edge 20.
        req[0] = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            if (e == 20) req[0] = 1'b0;
            step();
            if (e == 1)  chk("e1_clk_en", 32'(clk_en), 32'd1);
            if (e == 4)  chk("e4_state_wake", 32'(state), 32'd1);
            if (e == 5)  chk("e5_state_on", 32'(state), 32'd2);
            if (e == 5)  chk("e5_ack_low", 32'(ack), 32'd0);
            if (e == 6)  chk("e6_ack", 32'(ack), 32'd1);
            if (e == 6)  chk("e6_wake_cnt", 32'(wcnt), 32'd1);
            if (e == 20) chk("e20_ack_low", 32'(ack), 32'd0);
            if (e == 20) chk("e20_state_on", 32'(state), 32'd2);
            if (e == 21) chk("e21_state_hold", 32'(state), 32'd3);
            if (e == 36) chk("e36_clk_en", 32'(clk_en), 32'd1);
            if (e == 37) chk("e37_clk_en_off", 32'(clk_en), 32'd0);
            if (e == 37) chk("e37_state_off", 32'(state), 32'd0);
        end

        // Re-request five cycles into HOLD.
        req[0] = 1'b1;
        run_until(2, 20);
        repeat (3) step();
        w_saved = wcnt;
        req[0] = 1'b0;
        en_low = 1'b0;
        run_until(3, 10);
        repeat (5) begin
            step();
            if (!clk_en) en_low = 1'b1;
        end
        req[0] = 1'b1;
        step();
        chk("rehold_state_on", 32'(state), 32'd2);
        chk("rehold_ack_low", 32'(ack), 32'd0);
        step();
        chk("rehold_ack", 32'(ack), 32'd1);
        chk("rehold_no_off", 32'(en_low), 32'd0);
        chk("rehold_wake_cnt", 32'(wcnt), 32'(w_saved));
        req = '0;
        run_until(0, 60);

        // Concurrent requesters.
        req = 4'b1010;
        lat = 0;
        while (ack == '0 && lat < 20) begin
            step();
            lat++;
        end
        chk("conc_acks", 32'(ack), 32'hA);
        chk("conc_latency", 32'(lat), 32'(WAKE + 2));
        req[1] = 1'b0;
        step();
        chk("conc_drop1_ack", 32'(ack), 32'h8);
        repeat (5) step();
        chk("conc_still_on", 32'(state), 32'd2);
        req[3] = 1'b0;
        run_until(0, 60);

        // Abort pulse on requester 2, then force-on.
        ack2_seen = 1'b0;
        req[2] = 1'b1;
        step();
        step();
        req[2] = 1'b0;
        repeat (40) begin
            step();
            if (ack[2]) ack2_seen = 1'b1;
        end
        chk("abort_no_ack", 32'(ack2_seen), 32'd0);
        chk("abort_back_off", 32'(state), 32'd0);
        force_on = 1'b1;
        repeat (50) step();
        chk("force_clk_en", 32'(clk_en), 32'd1);
        chk("force_state", 32'(state), 32'd2);
        chk("force_ack", 32'(ack), 32'd0);
        force_on = 1'b0;
        run_until(0, 60);

        // Async reset while serving with acks high.
        req = 4'b0011;
        run_until(2, 20);
        step();
        step();
        chk("pre_rst_ack", 32'(ack), 32'h3);
        req = '0;
        async_reset();
        req[0] = 1'b1;
        lat = 0;
        while (ack == '0 && lat < 20) begin
            step();
            lat++;
        end
        chk("post_rst_latency", 32'(lat), 32'(WAKE + 2));
        chk("post_rst_wake_cnt", 32'(wcnt), 32'd1);
        req = '0;
        run_until(0, 60);

        // Randomized traffic, occasional force and mid-cycle reset.
        for (int seg = 0; seg < 300; seg++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4)      req = '0;
            else if (r < 6) req = 4'($urandom);
            else            req = 4'(1 << $urandom_range(0, NREQ - 1));
            force_on = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(1, 30)) step();
            if ($urandom_range(0, 39) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
